buf4_ptr_ctrl: RTL and testbench
================================

BUF4_PTR_CTRL -- requirements
Module: buf4_ptr_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning entry data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, fixed at 4, meaning number of buffer entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous clear of pointers; data contents are don't-care.
REQ-006 wr_valid  input  1  producer offers wr_data.
REQ-007 wr_ready  output  1  buffer accepts a write this cycle.
REQ-008 wr_data  input  DATA_W  write payload.
REQ-009 rd_valid  output  1  rd_data holds the oldest entry.
REQ-010 rd_ready  input  1  consumer takes rd_data.
REQ-011 rd_data  output  DATA_W  oldest entry.
REQ-012 W_Addr  output  2  next write slot, to the ready-mask stage.
REQ-013 R_Addr  output  2  next read slot, to the ready-mask stage.
REQ-014 Round  output  1  write pointer is one lap ahead of read pointer.
REQ-015 count  output  3  occupied entries, 0..4.
REQ-016 full / empty  output  1 each  count==4 / count==0.

Function
REQ-017 SHALL keep 3-bit pseudo pointers wp, rp; W_Addr=wp[1:0], R_Addr=rp[1:0], Round=wp[2]^rp[2].
REQ-018 SHALL compute count=(wp-rp) mod 8, always within 0..4, equal to the distance the mask stage derives from W_Addr, R_Addr and Round.
REQ-019 wr_ready SHALL equal !full; write fires when wr_valid&&wr_ready.
REQ-020 rd_valid SHALL equal !empty; read fires when rd_valid&&rd_ready.
REQ-021 On write fire: mem[W_Addr]<=wr_data, wp<=wp+1 (mod 8).
REQ-022 On read fire: rp<=rp+1 (mod 8).
REQ-023 Simultaneous write and read fire SHALL both occur; count unchanged.
REQ-024 When full, write SHALL NOT fire even if a read fires the same cycle; no pass-through.
REQ-025 When empty, rd_valid SHALL be 0; no write-to-read bypass; first-write latency to rd_valid is 1 cycle.
REQ-026 rd_data SHALL equal mem[R_Addr] combinationally; it is don't-care when empty.
REQ-027 Wrap: pointer 3->0 on the low bits SHALL toggle bit 2, so Round toggles on each lap of either pointer.
REQ-028 Round SHALL be 1 exactly when W_Addr<R_Addr, or when W_Addr==R_Addr and full.
REQ-029 flush SHALL set wp=rp=0 next cycle and override same-cycle write and read fires.
REQ-030 Handshake: wr_data SHALL be sampled only on write fire; rd_data/rd_valid SHALL stay stable while rd_valid && !rd_ready.

Reset
REQ-031 On reset: wp=0, rp=0, so W_Addr=0, R_Addr=0, Round=0, count=0, empty=1, full=0, wr_ready=1, rd_valid=0.
REQ-032 Reset SHALL override flush and all fires; storage array is not reset.
REQ-033 Reset asserted mid-operation SHALL discard all entries at the next edge.

Structure
REQ-034 Shared package SHALL hold BUF_DEPTH=4, PTR_W=2, PSEUDO_PTR_W=3, COUNT_W=3.
REQ-035 Storage SHALL be one sub-module buf4_regfile (1 write port, 1 async read port, DATA_W param); pointer/flag logic stays in buf4_ptr_ctrl.

Verification
REQ-036 Reset, then 4 writes 0xA0..0xA3 with rd_ready=0 -> full=1, wr_ready=0, count=4, W_Addr=0, R_Addr=0, Round=1.
REQ-037 From full, 1 read -> rd_data=0xA0 consumed, R_Addr=1, Round=1, count=3; then write 0xA4 -> W_Addr=1, count=4.
REQ-038 Continuous simultaneous write/read for 10 cycles at count=2 -> count stays 2, data order preserved, Round toggles at each pointer wrap and satisfies REQ-028.
REQ-039 Full with wr_valid=1 and rd_ready=1 -> read fires, write blocked, count=3 next cycle.
REQ-040 Empty with wr_valid=1 and rd_ready=1 -> rd_valid=0 that cycle, rd_valid=1 next cycle with the written data.
REQ-041 count=3 with Round=1, then reset (or flush) together with wr_valid -> next cycle all pointers 0, Round=0, empty=1.

Source files
------------

// File: rtl/buf4_ptr_ctrl_pkg.sv
// rtl/buf4_ptr_ctrl_pkg.sv - shared sizing constants for the 4-entry buffer
//
// Purpose: single source of truth for buffer depth and pointer/count widths,
//          imported by buf4_regfile and buf4_ptr_ctrl.
// Ports:   none (package).
package buf4_ptr_ctrl_pkg;

  localparam int BUF_DEPTH    = 4;
  localparam int PTR_W        = 2;  // slot index width
  localparam int PSEUDO_PTR_W = 3;  // slot index plus lap bit
  localparam int COUNT_W      = 3;  // holds 0..4

endpackage : buf4_ptr_ctrl_pkg

// File: rtl/buf4_regfile.sv
// rtl/buf4_regfile.sv - 4-entry storage, one write port, one async read port
//
// Purpose: plain register array behind the pointer controller. Contents are
//          not reset; the controller only reads slots it has written.
// Ports:
//   i_clk    clock, writes on rising edge
//   i_we     write enable
//   i_waddr  write slot
//   i_wdata  write payload
//   i_raddr  read slot
//   o_rdata  combinational read of slot i_raddr
module buf4_regfile
  import buf4_ptr_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = BUF_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : buf4_regfile

// File: rtl/buf4_ptr_ctrl.sv
// rtl/buf4_ptr_ctrl.sv - 4-entry FIFO buffer with lap-bit pseudo pointers
//
// Purpose: valid/ready buffer of four entries. Write and read pointers carry
//          an extra lap bit so full and empty are distinguishable; slot
//          addresses and the lap difference are exported to a ready-mask stage.
// Ports:
//   i_clk       clock
//   i_reset     synchronous active-high reset, overrides everything
//   i_flush     synchronous pointer clear, overrides same-cycle fires
//   i_wr_valid  producer offers i_wr_data
//   o_wr_ready  buffer can accept a write (not full)
//   i_wr_data   write payload
//   o_rd_valid  o_rd_data holds the oldest entry (not empty)
//   i_rd_ready  consumer takes o_rd_data
//   o_rd_data   oldest entry
//   o_w_addr    next write slot
//   o_r_addr    next read slot
//   o_round     write pointer is one lap ahead of read pointer
//   o_count     occupied entries 0..4
//   o_full      count == 4
//   o_empty     count == 0
module buf4_ptr_ctrl
  import buf4_ptr_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  input  logic [DATA_W-1:0]  i_wr_data,
  output logic               o_rd_valid,
  input  logic               i_rd_ready,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic [PTR_W-1:0]   o_w_addr,
  output logic [PTR_W-1:0]   o_r_addr,
  output logic               o_round,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_full,
  output logic               o_empty
);

  logic [PSEUDO_PTR_W-1:0] r_wp;
  logic [PSEUDO_PTR_W-1:0] r_rp;
  logic [COUNT_W-1:0]      w_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_wr_fire;
  logic                    w_rd_fire;
  logic                    w_clear;

  // Modulo-8 difference of the lap-extended pointers is the occupancy; the
  // pointers never drift more than 4 apart, so it stays within 0..4.
  assign w_count   = r_wp - r_rp;
  assign w_full    = (w_count == COUNT_W'(BUF_DEPTH));
  assign w_empty   = (w_count == '0);

  // Write is gated by full alone, so a same-cycle read never lets a write
  // into a full buffer.
  assign w_wr_fire = i_wr_valid && !w_full;
  assign w_rd_fire = i_rd_ready && !w_empty;
  assign w_clear   = i_reset || i_flush;

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr_fire) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_rd_fire) begin
        r_rp <= r_rp + 1'b1;
      end
    end
  end

  buf4_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_we    (w_wr_fire && !w_clear),
    .i_waddr (r_wp[PTR_W-1:0]),
    .i_wdata (i_wr_data),
    .i_raddr (r_rp[PTR_W-1:0]),
    .o_rdata (o_rd_data)
  );

  assign o_w_addr   = r_wp[PTR_W-1:0];
  assign o_r_addr   = r_rp[PTR_W-1:0];
  assign o_round    = r_wp[PSEUDO_PTR_W-1] ^ r_rp[PSEUDO_PTR_W-1];
  assign o_count    = w_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_wr_ready = !w_full;
  assign o_rd_valid = !w_empty;

endmodule : buf4_ptr_ctrl

// File: tb/tb_buf4_ptr_ctrl.sv
// tb/tb_buf4_ptr_ctrl.sv - scoreboard bench for buf4_ptr_ctrl
module tb_buf4_ptr_ctrl;

  logic        clk = 1'b0;
  logic        i_reset, i_flush, i_wr_valid, i_rd_ready;
  logic [31:0] i_wr_data;
  logic        o_wr_ready, o_rd_valid, o_round, o_full, o_empty;
  logic [31:0] o_rd_data;
  logic [1:0]  o_w_addr, o_r_addr;
  logic [2:0]  o_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] sb[$];
  logic [2:0]  m_wp = 3'd0;
  logic [2:0]  m_rp = 3'd0;

  always #5 clk = ~clk;

  buf4_ptr_ctrl #(.DATA_W(32), .DEPTH(4)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_flush    (i_flush),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .i_wr_data  (i_wr_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_rd_data  (o_rd_data),
    .o_w_addr   (o_w_addr),
    .o_r_addr   (o_r_addr),
    .o_round    (o_round),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty)
  );

  // Monitor: every read handshake pops the oldest expected payload.
  always @(negedge clk) begin
    if (o_rd_valid && i_rd_ready && !i_reset && !i_flush) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rd_data: read with nothing expected, got %h", o_rd_data);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (o_rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data: got %h expected %h", o_rd_data, e);
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model pointers follow what should fire.
  task automatic step(input bit wv, input logic [31:0] wd, input bit rr,
                      input bit fl = 1'b0, input bit rs = 1'b0);
    logic [2:0] mc;
    bit wf, rf;
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_rd_ready = rr;
    i_flush    = fl;
    i_reset    = rs;
    mc = m_wp - m_rp;
    wf = wv && (mc != 3'd4);
    rf = rr && (mc != 3'd0);
    @(posedge clk);
    if (rs || fl) begin
      m_wp = 3'd0;
      m_rp = 3'd0;
      sb.delete();
    end else begin
      if (wf) begin
        sb.push_back(wd);
        m_wp = m_wp + 3'd1;
      end
      if (rf) m_rp = m_rp + 3'd1;
    end
    #1;
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    i_flush    = 1'b0;
    i_reset    = 1'b0;
  endtask

  // Hand-supplied expected state; flags follow from the expected count.
  task automatic chk(input string tag, input int c, input int wa, input int ra, input int rnd);
    cmp({tag, ".count"},    32'(o_count),    32'(c));
    cmp({tag, ".full"},     32'(o_full),     32'(c == 4));
    cmp({tag, ".empty"},    32'(o_empty),    32'(c == 0));
    cmp({tag, ".wr_ready"}, 32'(o_wr_ready), 32'(c != 4));
    cmp({tag, ".rd_valid"}, 32'(o_rd_valid), 32'(c != 0));
    cmp({tag, ".w_addr"},   32'(o_w_addr),   32'(wa));
    cmp({tag, ".r_addr"},   32'(o_r_addr),   32'(ra));
    cmp({tag, ".round"},    32'(o_round),    32'(rnd));
  endtask

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_wr_valid = 1'b0; i_rd_ready = 1'b0; i_wr_data = '0;
    step(0, 0, 0, 0, 1);
    step(1, 32'h55, 1, 1, 1);
    chk("reset", 0, 0, 0, 0);

    // Fill to full with no reads.
    for (int i = 0; i < 4; i++) step(1, 32'hA0 + i, 0);
    chk("fill", 4, 0, 0, 1);

    // One read from full, then refill.
    step(0, 0, 1);
    chk("read1", 3, 0, 1, 1);
    step(1, 32'hA4, 0);
    chk("refill", 4, 1, 1, 1);

    // Full with both sides active: read fires, write (B0) is blocked.
    step(1, 32'hB0, 1);
    chk("full_both", 3, 1, 2, 1);

    // Down to two entries, then ten cycles of simultaneous traffic.
    step(0, 0, 1);
    chk("drain_to2", 2, 1, 3, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 32'hC0 + i, 1);
      chk("stream", 2, int'(m_wp[1:0]), int'(m_rp[1:0]), int'(m_wp[2] ^ m_rp[2]));
      cmp("stream.round_rule", 32'(o_round),
          32'((m_wp[1:0] < m_rp[1:0]) || ((m_wp[1:0] == m_rp[1:0]) && ((m_wp - m_rp) == 3'd4))));
    end
    // wp = 5+10 = 15 -> 7, rp = 5+... wp=7, rp=5 after stream
    chk("stream_end", 2, 3, 1, 0);

    step(0, 0, 1);
    step(0, 0, 1);
    chk("drained", 0, 3, 3, 0);
    cmp("sb_consumed", 32'(sb.size()), 32'd0);

    // Empty with write and read offered: no bypass.
    step(1, 32'hD0, 1);
    chk("empty_both", 1, 0, 3, 1);

    // Hold rd_ready low: oldest entry stays presented.
    step(1, 32'hD1, 0);
    cmp("hold0", o_rd_data, 32'hD0);
    step(0, 0, 0);
    cmp("hold1", o_rd_data, 32'hD0);
    cmp("hold1.rd_valid", 32'(o_rd_valid), 32'd1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("drained2", 0, 1, 1, 0);

    // count=3 with Round=1, then reset with a write offered.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'hE0 + i, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 32'hE4, 0);
    chk("pre_reset", 3, 1, 2, 1);
    step(1, 32'hEE, 1, 0, 1);
    chk("mid_reset", 0, 0, 0, 0);

    // Same setup, cleared by flush instead.
    for (int i = 0; i < 4; i++) step(1, 32'hF0 + i, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 32'hF4, 0);
    chk("pre_flush", 3, 1, 2, 1);
    step(1, 32'hFF, 1, 1, 0);
    chk("flush", 0, 0, 0, 0);

    // Buffer still works after flush.
    step(1, 32'h11, 0);
    chk("post_flush", 1, 1, 0, 0);
    step(0, 0, 1);
    chk("post_flush_rd", 0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_buf4_ptr_ctrl
